// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types and helpers for the pipelined parameterised ALU:
//                opcode encoding, LOGIC function select, sleep-FSM state
//                encoding and the LUT image width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'd0,
        OP_ADD   = 2'd1,
        OP_LUT   = 2'd2,
        OP_LOGIC = 2'd3
    } opcode_e;

    // Codes 0 and 3 both select XOR.
    typedef enum logic [1:0] {
        FN_XOR0 = 2'd0,
        FN_AND  = 2'd1,
        FN_OR   = 2'd2,
        FN_XOR  = 2'd3
    } func_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SLEEP = 2'd2,
        ST_WAKE  = 2'd3
    } sleep_state_e;

    // Width of the LUT truth-table image for a given LUT address width.
    function automatic int lut_width(input int aw);
        return 1 << aw;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Purely combinational ALU datapath. Produces a 2*NBITS-wide
//                result for MUL, ADD, LUT and LOGIC operations.
//  Ports       : i_a, i_b   NBITS operands
//                i_op       opcode (alu_pkg::opcode_e encoding)
//                i_func     LOGIC select (alu_pkg::func_e encoding)
//                i_lut      LUT truth-table image, 2**LUT_AW bits
//                o_res      2*NBITS result, zero-extended where narrower
//  Revision    : 1.0  initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int NBITS  = 8,
    parameter int LUT_AW = 3
) (
    input  logic [NBITS-1:0]             i_a,
    input  logic [NBITS-1:0]             i_b,
    input  logic [1:0]                   i_op,
    input  logic [1:0]                   i_func,
    input  logic [lut_width(LUT_AW)-1:0] i_lut,
    output logic [2*NBITS-1:0]           o_res
);

    localparam int c_RW = 2 * NBITS;

    // Operands widened to the result width so the product and the carry of
    // the sum are kept without truncation.
    logic [c_RW-1:0]  w_a_ext;
    logic [c_RW-1:0]  w_b_ext;
    logic [NBITS-1:0] w_logic;

    assign w_a_ext = {{NBITS{1'b0}}, i_a};
    assign w_b_ext = {{NBITS{1'b0}}, i_b};

    always_comb begin
        w_logic = i_a ^ i_b;
        case (i_func)
            FN_AND:  w_logic = i_a & i_b;
            FN_OR:   w_logic = i_a | i_b;
            default: w_logic = i_a ^ i_b;
        endcase
    end

    always_comb begin
        o_res = '0;
        case (i_op)
            OP_MUL:   o_res = w_a_ext * w_b_ext;
            OP_ADD:   o_res = w_a_ext + w_b_ext;
            OP_LUT:   o_res = {{(c_RW-1){1'b0}}, i_lut[i_a[LUT_AW-1:0]]};
            default:  o_res = {{NBITS{1'b0}}, w_logic};
        endcase
    end

endmodule : alu_core
`default_nettype wire

// File: rtl/param_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : param_alu_pipe
//  Description : Two-stage pipelined ALU with valid/ready handshakes on both
//                sides and a RUN/DRAIN/SLEEP/WAKE power-down FSM.
//                S1 registers the operation, S2 registers the result.
//  Ports       : clk, rst_n            clock, async active-low reset
//                in_valid/in_ready     input handshake
//                A, B, OP_CODE, FuncL  operation (operands, opcode, LOGIC sel)
//                Lut_prog              LUT image, sampled with the operation
//                O/out_valid/out_ready result handshake
//                go_sleep/sleep_ack    1=run, 0=sleep request / drained ack
//  Revision    : 1.0  initial release
// ============================================================================
module param_alu_pipe
    import alu_pkg::*;
#(
    parameter int NBITS  = 8,
    parameter int LUT_AW = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NBITS-1:0]             A,
    input  logic [NBITS-1:0]             B,
    input  logic [1:0]                   OP_CODE,
    input  logic [1:0]                   FuncL,
    input  logic [lut_width(LUT_AW)-1:0] Lut_prog,
    output logic [2*NBITS-1:0]           O,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         go_sleep,
    output logic                         sleep_ack
);

    localparam int         c_LW       = lut_width(LUT_AW);
    localparam logic [1:0] c_ST_RUN   = ST_RUN;
    localparam logic [1:0] c_ST_DRAIN = ST_DRAIN;
    localparam logic [1:0] c_ST_SLEEP = ST_SLEEP;
    localparam logic [1:0] c_ST_WAKE  = ST_WAKE;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic               r_s1_vld;
    logic [NBITS-1:0]   r_s1_a;
    logic [NBITS-1:0]   r_s1_b;
    logic [1:0]         r_s1_op;
    logic [1:0]         r_s1_func;
    logic [c_LW-1:0]    r_s1_lut;

    logic               r_s2_vld;
    logic [2*NBITS-1:0] r_s2_o;

    logic [2*NBITS-1:0] w_core_res;
    logic               w_s1_load;
    logic               w_s2_load;

    alu_core #(
        .NBITS  (NBITS),
        .LUT_AW (LUT_AW)
    ) u_core (
        .i_a    (r_s1_a),
        .i_b    (r_s1_b),
        .i_op   (r_s1_op),
        .i_func (r_s1_func),
        .i_lut  (r_s1_lut),
        .o_res  (w_core_res)
    );

    // S2 takes a new result when it is empty or its current one leaves now;
    // S1 drains into S2 on the same condition.
    assign w_s2_load = r_s1_vld && (!r_s2_vld || out_ready);

    // go_sleep is folded in combinationally so an operation presented in the
    // very cycle the sleep request appears is refused. rst_n gating keeps
    // in_ready low for the whole time reset is asserted.
    assign in_ready  = rst_n && go_sleep && (r_state == c_ST_RUN)
                     && (!r_s1_vld || w_s2_load);
    assign w_s1_load = in_valid && in_ready;

    assign out_valid = r_s2_vld;
    assign O         = (r_state == c_ST_SLEEP) ? '0 : r_s2_o;
    assign sleep_ack = (r_state == c_ST_SLEEP);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_RUN: begin
                if (!go_sleep) w_state_nxt = c_ST_DRAIN;
            end
            c_ST_DRAIN: begin
                if (go_sleep)                     w_state_nxt = c_ST_RUN;
                else if (!r_s1_vld && !r_s2_vld)  w_state_nxt = c_ST_SLEEP;
            end
            c_ST_SLEEP: begin
                if (go_sleep) w_state_nxt = c_ST_WAKE;
            end
            default: begin
                w_state_nxt = c_ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_RUN;
            r_s1_vld  <= 1'b0;
            r_s1_a    <= '0;
            r_s1_b    <= '0;
            r_s1_op   <= '0;
            r_s1_func <= '0;
            r_s1_lut  <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_o    <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_s1_load) begin
                r_s1_a    <= A;
                r_s1_b    <= B;
                r_s1_op   <= OP_CODE;
                r_s1_func <= FuncL;
                r_s1_lut  <= Lut_prog;
            end

            if (w_s1_load)      r_s1_vld <= 1'b1;
            else if (w_s2_load) r_s1_vld <= 1'b0;

            if (w_s2_load) begin
                r_s2_vld <= 1'b1;
                r_s2_o   <= w_core_res;
            end else if (out_ready) begin
                r_s2_vld <= 1'b0;
            end
        end
    end

endmodule : param_alu_pipe
`default_nettype wire

// File: tb/tb_param_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_alu_pipe
//  Description : Directed self-checking bench for param_alu_pipe
//                (NBITS=8, LUT_AW=3) with hand-computed expected values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_param_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [1:0]  OP_CODE;
    logic [1:0]  FuncL;
    logic [7:0]  Lut_prog;
    logic [15:0] O;
    logic        out_valid;
    logic        out_ready;
    logic        go_sleep;
    logic        sleep_ack;

    int total    = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    logic [1:0]  v_op [10];
    logic [7:0]  v_a  [10];
    logic [7:0]  v_b  [10];
    logic [1:0]  v_fn [10];
    logic [7:0]  v_lut[10];
    logic [15:0] v_ex [10];
    int          tx;
    int          rx;
    logic        saw_block;

    param_alu_pipe #(
        .NBITS  (8),
        .LUT_AW (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .OP_CODE   (OP_CODE),
        .FuncL     (FuncL),
        .Lut_prog  (Lut_prog),
        .O         (O),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .go_sleep  (go_sleep),
        .sleep_ack (sleep_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] fn, input logic [7:0] lut);
        in_valid = 1'b1;
        OP_CODE  = op;
        A        = a;
        B        = b;
        FuncL    = fn;
        Lut_prog = lut;
    endtask

    // One isolated operation: accept, wait one more edge, check the result.
    task automatic run_one(input string tag, input logic [1:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [1:0] fn, input logic [7:0] lut,
                           input logic [15:0] exp);
        drive(op, a, b, fn, lut);
        tick();
        in_valid = 1'b0;
        tick();
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk(tag, {16'd0, O}, {16'd0, exp});
        tick();
    endtask

    initial begin
        // ops: MUL 15*17, ADD 128+128, AND, LUT idx0, MUL 255*255, ADD 0+0,
        //      OR, LUT idx7, XOR(code 0), MUL 16*16
        v_op  = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3, 2'd2, 2'd3, 2'd0};
        v_a   = '{8'd15, 8'd128, 8'hAA, 8'h08, 8'd255, 8'd0, 8'h50, 8'd7, 8'hFF, 8'd16};
        v_b   = '{8'd17, 8'd128, 8'h0F, 8'h77, 8'd255, 8'd0, 8'h05, 8'h00, 8'h0F, 8'd16};
        v_fn  = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0};
        v_lut = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00};
        v_ex  = '{16'h00FF, 16'h0100, 16'h000A, 16'h0001, 16'hFE01,
                  16'h0000, 16'h0055, 16'h0001, 16'h00F0, 16'h0100};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        OP_CODE   = '0;
        FuncL     = '0;
        Lut_prog  = '0;
        out_ready = 1'b1;
        go_sleep  = 1'b1;

        // ---- reset state ----
        tick();
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_O", {16'd0, O}, 32'd0);
        chk("rst_sleep_ack", {31'd0, sleep_ack}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ---- back-to-back MUL then ADD, latency 2 ----
        drive(2'd0, 8'd200, 8'd100, 2'd0, 8'h00);
        tick();
        drive(2'd1, 8'd255, 8'd1, 2'd0, 8'h00);
        chk("b2b_lat1_vld", {31'd0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("b2b_mul_vld", {31'd0, out_valid}, 32'd1);
        chk("b2b_mul", {16'd0, O}, 32'd20000);
        tick();
        chk("b2b_add_vld", {31'd0, out_valid}, 32'd1);
        chk("b2b_add", {16'd0, O}, 32'd256);
        tick();
        chk("b2b_empty", {31'd0, out_valid}, 32'd0);

        // ---- LUT and LOGIC ----
        run_one("lut_a5", 2'd2, 8'd5, 8'hFF, 2'd0, 8'hA6, 16'h0001);
        run_one("lut_a0", 2'd2, 8'd0, 8'h00, 2'd0, 8'hA6, 16'h0000);
        run_one("xor_f3", 2'd3, 8'hF0, 8'h3C, 2'd3, 8'h00, 16'h00CC);
        run_one("and_f1", 2'd3, 8'hF0, 8'h3C, 2'd1, 8'h00, 16'h0030);
        run_one("or_f2",  2'd3, 8'hF0, 8'h3C, 2'd2, 8'h00, 16'h00FC);
        run_one("xor_f0", 2'd3, 8'hF0, 8'h3C, 2'd0, 8'h00, 16'h00CC);

        // ---- 10-op stream with a 5-cycle consumer stall ----
        tx = 0;
        rx = 0;
        saw_block = 1'b0;
        for (int cyc = 0; cyc < 60 && rx < 10; cyc++) begin
            out_ready = !(cyc >= 4 && cyc < 9);
            if (tx < 10) drive(v_op[tx], v_a[tx], v_b[tx], v_fn[tx], v_lut[tx]);
            else         in_valid = 1'b0;
            #1;
            if (out_valid && rx < 10) begin
                chk($sformatf("stream%0d%s", rx, out_ready ? "" : "_hold"),
                    {16'd0, O}, {16'd0, v_ex[rx]});
                if (out_ready) rx++;
            end
            if (in_valid && in_ready) tx++;
            if (!out_ready && !in_ready) saw_block = 1'b1;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", rx, 32'd10);
        chk("stream_in_ready_drop", {31'd0, saw_block}, 32'd1);
        tick();
        chk("stream_no_dup", {31'd0, out_valid}, 32'd0);

        // ---- sleep with two ops in flight ----
        drive(2'd0, 8'd3, 8'd4, 2'd0, 8'h00);
        tick();
        drive(2'd1, 8'd5, 8'd6, 2'd0, 8'h00);
        tick();
        in_valid = 1'b0;
        go_sleep = 1'b0;
        #1;
        chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
        chk("drain_r1", {16'd0, O}, 32'd12);
        tick();
        chk("drain_r2_vld", {31'd0, out_valid}, 32'd1);
        chk("drain_r2", {16'd0, O}, 32'd11);
        tick();
        chk("drain_empty", {31'd0, out_valid}, 32'd0);
        chk("drain_not_slept", {31'd0, sleep_ack}, 32'd0);
        tick();
        chk("sleep_ack", {31'd0, sleep_ack}, 32'd1);
        chk("sleep_O", {16'd0, O}, 32'd0);
        chk("sleep_in_ready", {31'd0, in_ready}, 32'd0);
        go_sleep = 1'b1;
        tick();
        chk("wake_ack", {31'd0, sleep_ack}, 32'd0);
        chk("wake_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("run_in_ready", {31'd0, in_ready}, 32'd1);

        // ---- sleep request with empty pipe, coinciding with in_valid ----
        drive(2'd0, 8'd9, 8'd9, 2'd0, 8'h00);
        go_sleep = 1'b0;
        #1;
        chk("coinc_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("empty_drain_ack", {31'd0, sleep_ack}, 32'd0);
        tick();
        chk("empty_sleep_ack", {31'd0, sleep_ack}, 32'd1);
        chk("coinc_not_accepted", {31'd0, out_valid}, 32'd0);
        go_sleep = 1'b1;
        tick();
        tick();
        chk("rewake_in_ready", {31'd0, in_ready}, 32'd1);

        // ---- asynchronous reset mid-stream ----
        drive(2'd0, 8'd10, 8'd10, 2'd0, 8'h00);
        tick();
        drive(2'd1, 8'd1, 8'd2, 2'd0, 8'h00);
        tick();
        in_valid = 1'b0;
        chk("pre_rst_vld", {31'd0, out_valid}, 32'd1);
        chk("pre_rst_O", {16'd0, O}, 32'd100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_vld", {31'd0, out_valid}, 32'd0);
        chk("async_rst_O", {16'd0, O}, 32'd0);
        chk("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("rel_no_stale_vld", {31'd0, out_valid}, 32'd0);
        chk("rel_no_stale_O", {16'd0, O}, 32'd0);
        tick();
        chk("rel_no_stale_vld2", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule : tb_param_alu_pipe
`default_nettype wire
